multiplicacao_5por4_seq: RTL and testbench

MULTIPLICACAO_5POR4_SEQ -- requirements
Module: multiplicacao_5por4_seq

---
 rtl/multiplicacao_5por4_seq.sv | 107 ++++++++++
 tb/tb_multiplicacao_5por4_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multiplicacao_5por4_seq.sv
// Sequential 5x4 unsigned shift-and-add multiplier with a three-state control FSM.
// Latency: done pulses 4 edges after the start edge; one result per 6 cycles back-to-back.
// Backpressure: start is ignored while busy; results hold until the next completion edge.
module multiplicacao_5por4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [8:0] p,
  output logic [4:0] s,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  a_q;
  logic [3:0]  b_q;
  logic [8:0]  acc;
  logic [1:0]  cnt;
  logic [8:0]  p_q;
  logic [8:0]  addend;
  logic [8:0]  acc_nxt;
  logic        accept;
  logic        last_iter;

  // Partial product for the current multiplier bit; 9 bits holds 31*15 so no carry is lost.
  always_comb begin
    addend    = b_q[cnt] ? ({4'b0000, a_q} << cnt) : 9'd0;
    acc_nxt   = acc + addend;
    accept    = (state == IDLE) && start;
    last_iter = (state == RUN) && (cnt == 2'd3);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs; DONE lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latches, accumulator and iteration counter; all four iterations always run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= 5'd0;
      b_q <= 4'd0;
      acc <= 9'd0;
      cnt <= 2'd0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      acc <= 9'd0;
      cnt <= 2'd0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      // Counter saturates at 3 so it can never wrap inside an operation.
      if (cnt != 2'd3) cnt <= cnt + 2'd1;
    end
  end

  // Result register only updates on the final iteration, hiding intermediate sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= 9'd0;
    end else if (last_iter) begin
      p_q <= acc_nxt;
    end
  end

  assign p   = p_q;
  assign s   = p_q[4:0];
  assign ovf = |p_q[8:5];

endmodule

// File: tb/tb_multiplicacao_5por4_seq.sv
// Directed bench for the sequential 5x4 multiplier.
// Inputs change #1 after a rising edge; outputs are sampled at that same point.
// Each scenario task checks its own expectations against hand-computed values.
module tb_multiplicacao_5por4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [8:0] p;
  logic [4:0] s;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  multiplicacao_5por4_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .s     (s),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation with a start pulse and observes it; operands are
  // scrambled right after acceptance so the latching is exercised too.
  task automatic do_op(input logic [4:0] av, input logic [3:0] bv,
                       output int lat, output int nb, output int nd,
                       output logic [8:0] pv, output logic hold_ok);
    logic [8:0] p0;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0; a = ~av; b = ~bv;
    p0 = p; nb = busy ? 1 : 0; nd = 0; lat = -1; pv = 9'd0; hold_ok = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (busy) nb++;
      if (done) begin
        nd++;
        if (lat < 0) begin lat = n; pv = p; end
      end else if (lat < 0 && p !== p0) begin
        hold_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 5'd0; b = 4'd0;
    #3;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (p !== 9'd0) begin bad++; $display("FAIL reset_p got=%0d exp=0", p); end
    total++; if (s !== 5'd0) begin bad++; $display("FAIL reset_s got=%0d exp=0", s); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    #20;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, nb, nd; logic [8:0] pv; logic hold_ok;
    do_op(5'd5, 4'd3, lat, nb, nd, pv, hold_ok);
    total++; if (lat != 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    total++; if (nb != 5) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=5", nb); end
    total++; if (nd != 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", nd); end
    total++; if (pv !== 9'd15) begin bad++; $display("FAIL basic_p got=%0d exp=15", pv); end
    total++; if (s !== 5'd15) begin bad++; $display("FAIL basic_s got=%0d exp=15", s); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", ovf); end
    total++; if (!hold_ok) begin bad++; $display("FAIL basic_p_hold got=changed exp=stable"); end
  endtask

  task automatic test_max();
    int lat, nb, nd; logic [8:0] pv; logic hold_ok;
    do_op(5'd31, 4'd15, lat, nb, nd, pv, hold_ok);
    total++; if (lat != 4) begin bad++; $display("FAIL max_latency got=%0d exp=4", lat); end
    total++; if (pv !== 9'd465) begin bad++; $display("FAIL max_p got=%0d exp=465", pv); end
    total++; if (p !== 9'd465) begin bad++; $display("FAIL max_p_held got=%0d exp=465", p); end
    total++; if (s !== 5'd17) begin bad++; $display("FAIL max_s got=%0d exp=17", s); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL max_ovf got=%b exp=1", ovf); end
    total++; if (!hold_ok) begin bad++; $display("FAIL max_p_hold got=changed exp=stable"); end
  endtask

  task automatic test_zero();
    int lat, nb, nd; logic [8:0] pv; logic hold_ok;
    do_op(5'd0, 4'd9, lat, nb, nd, pv, hold_ok);
    total++; if (lat != 4) begin bad++; $display("FAIL zero_a_latency got=%0d exp=4", lat); end
    total++; if (pv !== 9'd0) begin bad++; $display("FAIL zero_a_p got=%0d exp=0", pv); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL zero_a_ovf got=%b exp=0", ovf); end
    do_op(5'd22, 4'd0, lat, nb, nd, pv, hold_ok);
    total++; if (lat != 4) begin bad++; $display("FAIL zero_b_latency got=%0d exp=4", lat); end
    total++; if (nb != 5) begin bad++; $display("FAIL zero_b_busy_cycles got=%0d exp=5", nb); end
    total++; if (pv !== 9'd0) begin bad++; $display("FAIL zero_b_p got=%0d exp=0", pv); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL zero_b_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_ignore_start();
    int nd; int lat; logic [8:0] pv;
    a = 5'd7; b = 4'd2; start = 1'b1;
    tick();
    a = 5'd31; b = 4'd15;
    nd = 0; lat = -1; pv = 9'd0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      if (done) begin nd++; if (lat < 0) begin lat = n; pv = p; end end
    end
    start = 1'b0;
    for (int n = 6; n <= 12; n++) begin
      tick();
      if (done) nd++;
    end
    total++; if (lat != 4) begin bad++; $display("FAIL ignore_latency got=%0d exp=4", lat); end
    total++; if (pv !== 9'd14) begin bad++; $display("FAIL ignore_p got=%0d exp=14", pv); end
    total++; if (nd != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", nd); end
    total++; if (p !== 9'd14) begin bad++; $display("FAIL ignore_p_held got=%0d exp=14", p); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_abort();
    int lat, nb, nd, nd_abort; logic [8:0] pv; logic hold_ok;
    a = 5'd12; b = 4'd11; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (p !== 9'd0) begin bad++; $display("FAIL abort_p got=%0d exp=0", p); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
    nd_abort = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (done || busy) nd_abort++;
    end
    total++; if (nd_abort != 0) begin bad++; $display("FAIL abort_activity got=%0d exp=0", nd_abort); end
    rst_n = 1'b1;
    do_op(5'd12, 4'd11, lat, nb, nd, pv, hold_ok);
    total++; if (lat != 4) begin bad++; $display("FAIL post_reset_latency got=%0d exp=4", lat); end
    total++; if (pv !== 9'd132) begin bad++; $display("FAIL post_reset_p got=%0d exp=132", pv); end
    total++; if (s !== 5'd4) begin bad++; $display("FAIL post_reset_s got=%0d exp=4", s); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL post_reset_ovf got=%b exp=1", ovf); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] av [3];
    logic [3:0] bv [3];
    logic [8:0] pexp [3];
    int t_done [3];
    logic [8:0] p_got [3];
    int k;
    av[0] = 5'd3;  bv[0] = 4'd4;  pexp[0] = 9'd12;
    av[1] = 5'd9;  bv[1] = 4'd9;  pexp[1] = 9'd81;
    av[2] = 5'd31; bv[2] = 4'd1;  pexp[2] = 9'd31;
    for (int i = 0; i < 3; i++) begin t_done[i] = -1; p_got[i] = 9'd0; end
    k = 0;
    a = av[0]; b = bv[0]; start = 1'b1;
    tick();
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (done) begin
        if (k < 3) begin t_done[k] = n; p_got[k] = p; end
        k++;
        if (k < 3) begin a = av[k]; b = bv[k]; end
        else start = 1'b0;
      end
    end
    start = 1'b0;
    total++; if (k != 3) begin bad++; $display("FAIL b2b_done_count got=%0d exp=3", k); end
    total++; if (t_done[0] != 4) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=4", t_done[0]); end
    for (int i = 1; i < 3; i++) begin
      total++;
      if (t_done[i] - t_done[i-1] != 6) begin
        bad++; $display("FAIL b2b_spacing%0d got=%0d exp=6", i, t_done[i] - t_done[i-1]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (p_got[i] !== pexp[i]) begin
        bad++; $display("FAIL b2b_p%0d got=%0d exp=%0d", i, p_got[i], pexp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
